// File: rtl/sel_demux_stream.sv
// Purpose : registered 1-to-4 stream demux; each beat goes to the channel named by in_sel.
// Latency : 1 cycle from input accept to out_valid on the chosen channel.
// Backpr. : in_ready follows only the addressed channel; a stalled channel never blocks the others.
//
// Ports:
//   clk, rst_n            single rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_sel picks channel 0..3, in_data is the payload
//   out_valid[k]          channel k holds a beat; out_ready[k] is its downstream accept
//   out_data              channel k payload at [k*DW +: DW]; holds last value when not valid
//   beat_cnt              only when DEMUX_CNT_EN is defined: 8-bit wrapping accept count
//                         per channel, channel k at [k*8 +: 8]
//
// Build option: define DEMUX_CNT_EN to add the per-channel beat counters.

module sel_demux_stream #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_sel,
    input  logic [DW-1:0]   in_data,
    output logic [3:0]      out_valid,
    input  logic [3:0]      out_ready,
    output logic [4*DW-1:0] out_data
`ifdef DEMUX_CNT_EN
    ,
    output logic [31:0]     beat_cnt
`endif
);

    logic [3:0]    ch_vld;
    logic [DW-1:0] ch_data [4];
    logic          accept;
    logic [3:0]    load;

    // A channel can take a new beat when empty or when its current beat
    // drains this same cycle; this is what gives 1 beat/cycle per channel.
    assign in_ready = ~ch_vld[in_sel] | out_ready[in_sel];
    assign accept   = in_valid & in_ready;
    assign load     = {4{accept}} & (4'b0001 << in_sel);

    // Load takes priority over drain, so a simultaneous drain+load leaves
    // the channel valid with the new payload. Clearing an already-empty
    // channel on out_ready is harmless, so no valid qualifier is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_vld <= '0;
            for (int k = 0; k < 4; k++) begin
                ch_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    ch_vld[k]  <= 1'b1;
                    ch_data[k] <= in_data;
                end else if (out_ready[k]) begin
                    ch_vld[k]  <= 1'b0;
                end
            end
        end
    end

    assign out_valid = ch_vld;

    for (genvar k = 0; k < 4; k++) begin : g_out
        assign out_data[k*DW +: DW] = ch_data[k];
    end

`ifdef DEMUX_CNT_EN
    logic [7:0] cnt [4];

    // Counts accepts per channel; wraps silently at 255 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    cnt[k] <= cnt[k] + 8'd1;
                end
            end
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_cnt
        assign beat_cnt[k*8 +: 8] = cnt[k];
    end
`endif

endmodule

// File: tb/tb_sel_demux_stream.sv
// Bench for sel_demux_stream: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a per-channel queue model.

module tb_sel_demux_stream;

    localparam int DW = 8;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_sel;
    logic [DW-1:0]   in_data;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [4*DW-1:0] out_data;
`ifdef DEMUX_CNT_EN
    logic [31:0]     beat_cnt;
`endif

    sel_demux_stream #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef DEMUX_CNT_EN
        ,
        .beat_cnt  (beat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each channel is a queue of accepted-but-not-yet-drained beats,
    // plus the last payload ever loaded and the accept count.
    logic [DW-1:0] q [4][$];
    logic [DW-1:0] mlast [4];
    logic [7:0]    mcnt [4];
    int            drained [4];
    logic          prev_stall;
    logic [1:0]    ps_sel;
    logic [DW-1:0] ps_data;

    int checks;
    int errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic model_ready(input logic [1:0] s, input logic [3:0] rdy);
        return (q[s].size() == 0) || rdy[s];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            q[k].delete();
            mlast[k]   = '0;
            mcnt[k]    = '0;
            drained[k] = 0;
        end
        prev_stall = 1'b0;
    endtask

    task automatic compare_outputs();
        logic [3:0] ev;
        for (int k = 0; k < 4; k++) begin
            ev[k] = (q[k].size() != 0);
            chk($sformatf("out_data[%0d]", k), 32'(out_data[k*DW +: DW]), 32'(mlast[k]));
`ifdef DEMUX_CNT_EN
            chk($sformatf("beat_cnt[%0d]", k), 32'(beat_cnt[k*8 +: 8]), 32'(mcnt[k]));
`endif
        end
        chk("out_valid", 32'(out_valid), 32'(ev));
    endtask

    // Inputs are already applied; checks in_ready, clocks once, updates the
    // model from the driven inputs and compares the registered outputs.
    task automatic step();
        logic acc;
        logic [DW-1:0] d;
        #1;
        chk("in_ready", 32'(in_ready), 32'(model_ready(in_sel, out_ready)));
        @(posedge clk);
        if (prev_stall) begin
            chk("src_stable", {22'd0, in_sel, in_data}, {22'd0, ps_sel, ps_data});
        end
        acc = in_valid && model_ready(in_sel, out_ready);
        for (int k = 0; k < 4; k++) begin
            if (q[k].size() != 0 && out_ready[k]) begin
                d = q[k].pop_front();
                drained[k]++;
            end
        end
        if (acc) begin
            q[in_sel].push_back(in_data);
            mlast[in_sel] = in_data;
            mcnt[in_sel]  = mcnt[in_sel] + 8'd1;
        end
        prev_stall = in_valid && !acc;
        ps_sel     = in_sel;
        ps_data    = in_data;
        #1;
        compare_outputs();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        model_clear();
        chk("rst out_valid", 32'(out_valid), 32'h0);
        chk("rst out_data", out_data, 32'h0);
`ifdef DEMUX_CNT_EN
        chk("rst beat_cnt", beat_cnt, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = '0;
        out_ready = 4'b0000;
        model_clear();
        #2;

        // Reset: in_ready must be 1 for every in_sel while held in reset.
        rst_n = 1'b0;
        #1;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            chk($sformatf("rst in_ready sel%0d", s), 32'(in_ready), 32'h1);
        end
        do_reset();

        // Routing to channel 2.
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5; out_ready = 4'b0000;
        step();
        chk("route out_valid", 32'(out_valid), 32'h4);
        chk("route data ch2", 32'(out_data[23:16]), 32'hA5);
        in_data = 8'h5A;
        #1;
        chk("full ch2 in_ready", 32'(in_ready), 32'h0);

        // Back-pressure isolation: channel 1 still accepts.
        in_sel = 2'd1; in_data = 8'h3C;
        #1;
        chk("iso in_ready", 32'(in_ready), 32'h1);
        step();
        chk("iso out_valid", 32'(out_valid), 32'h6);
        chk("iso ch2 held", 32'(out_data[23:16]), 32'hA5);
        chk("iso ch1 data", 32'(out_data[15:8]), 32'h3C);

        // Simultaneous drain and load on channel 0.
        in_sel = 2'd0; in_data = 8'h11;
        step();
        out_ready = 4'b0001; in_data = 8'h22;
        step();
        chk("dl out_valid0", 32'(out_valid[0]), 32'h1);
        chk("dl data ch0", 32'(out_data[7:0]), 32'h22);
        chk("dl drained once", 32'(drained[0]), 32'h1);
        in_valid = 1'b0;
        step();
        chk("dl drain 22", 32'(drained[0]), 32'h2);
        chk("dl out_valid", 32'(out_valid), 32'h6);

        // Build out_valid=0101 then reset mid-operation.
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h77; out_ready = 4'b0110;
        step();
        in_sel = 2'd2; in_data = 8'h99; out_ready = 4'b0000;
        step();
        chk("pre-rst out_valid", 32'(out_valid), 32'h5);
        do_reset();

        // 256 beats to channel 3 with all channels ready.
        out_ready = 4'b1111; in_sel = 2'd3; in_valid = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            in_data = 8'($urandom);
            step();
`ifdef DEMUX_CNT_EN
            if (i == 255) chk("wrap 255", 32'(beat_cnt[31:24]), 32'd255);
            if (i == 256) begin
                chk("wrap 0", 32'(beat_cnt[31:24]), 32'd0);
                chk("wrap others", 32'(beat_cnt[23:0]), 32'd0);
            end
`endif
        end
        chk("wrap model cnt", 32'(mcnt[3]), 32'd0);

        // Randomized traffic with varying downstream readiness.
        for (int i = 0; i < 3000; i++) begin
            if (!prev_stall) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 2'($urandom);
                in_data  = 8'($urandom);
            end
            if (i < 1000)
                out_ready = 4'($urandom);
            else if (i < 2000)
                out_ready = 4'($urandom) & 4'($urandom);
            else
                out_ready = 4'($urandom) | 4'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
